// File: rtl/match_sequencer.sv
// Match sequencer for a ball game: serve handling, point pauses, match end.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tick                       one-cycle time-base pulse
//   serve, serve_type          serve trigger (rising edge used), 0 auto / 1 manual
//   mode                       game mode; a change outside IDLE aborts the match
//   point_p1, point_p2         one-cycle scoring pulses
//   p1_score, p2_score         current scores from the datapath
//   ball_en, ball_launch       ball motion enable, one-cycle reload pulse
//   serve_side                 0 = player 1 serves, 1 = player 2 serves
//   score_clr                  one-cycle clear of both scores
//   game_over, winner          match finished, winning player
//   state                      current FSM state
module match_sequencer #(
   parameter logic [4:0] WIN_SCORE   = 5'd15,
   parameter logic [7:0] AUTO_DELAY  = 8'd30,
   parameter logic [7:0] PAUSE_TICKS = 8'd60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       serve,
   input  logic       serve_type,
   input  logic [1:0] mode,
   input  logic       point_p1,
   input  logic       point_p2,
   input  logic [4:0] p1_score,
   input  logic [4:0] p2_score,
   output logic       ball_en,
   output logic       ball_launch,
   output logic       serve_side,
   output logic       score_clr,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_SERVE_WAIT  = 3'd1;
   localparam logic [2:0] S_PLAY        = 3'd2;
   localparam logic [2:0] S_POINT_PAUSE = 3'd3;
   localparam logic [2:0] S_GAME_OVER   = 3'd4;

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       serve_prev_q;
   logic [1:0] mode_prev_q;
   logic       ball_en_q, ball_en_d;
   logic       ball_launch_q, ball_launch_d;
   logic       serve_side_q, serve_side_d;
   logic       score_clr_q, score_clr_d;
   logic       game_over_q, game_over_d;
   logic       winner_q, winner_d;

   logic serve_edge;
   logic mode_chg;
   logic p1_won;
   logic p2_won;

   assign serve_edge = serve & ~serve_prev_q;
   assign mode_chg   = (mode != mode_prev_q);
   assign p1_won     = (p1_score >= WIN_SCORE);
   assign p2_won     = (p2_score >= WIN_SCORE);

   // Next-state, counter and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      serve_side_d = serve_side_q;
      winner_d     = winner_q;
      score_clr_d  = 1'b0;

      // Mode change outranks every other transition
      if (mode_chg && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         score_clr_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (serve_edge) state_d = S_SERVE_WAIT;
            end
            S_SERVE_WAIT: begin
               if (serve_type) begin
                  if (serve_edge) state_d = S_PLAY;
               end else if (tick && (cnt_q == AUTO_DELAY - 8'd1)) begin
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               // Conceding player serves next; p1 wins a simultaneous pair
               if (point_p1) begin
                  state_d      = S_POINT_PAUSE;
                  serve_side_d = 1'b1;
               end else if (point_p2) begin
                  state_d      = S_POINT_PAUSE;
                  serve_side_d = 1'b0;
               end
            end
            S_POINT_PAUSE: begin
               if (tick && (cnt_q == PAUSE_TICKS - 8'd1)) begin
                  if (p1_won || p2_won) begin
                     state_d  = S_GAME_OVER;
                     winner_d = p2_won & ~p1_won;
                  end else begin
                     state_d = S_SERVE_WAIT;
                  end
               end
            end
            S_GAME_OVER: begin
               if (serve_edge) begin
                  state_d      = S_IDLE;
                  score_clr_d  = 1'b1;
                  serve_side_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Counter restarts on every state entry
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end else if (tick && ((state_q == S_SERVE_WAIT) || (state_q == S_POINT_PAUSE))) begin
         cnt_d = cnt_q + 8'd1;
      end

      if (state_d != S_GAME_OVER) winner_d = 1'b0;

      ball_en_d     = (state_d == S_PLAY);
      ball_launch_d = (state_d == S_PLAY) && (state_q != S_PLAY);
      game_over_d   = (state_d == S_GAME_OVER);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 8'd0;
         serve_prev_q  <= 1'b0;
         mode_prev_q   <= 2'b00;
         ball_en_q     <= 1'b0;
         ball_launch_q <= 1'b0;
         serve_side_q  <= 1'b0;
         score_clr_q   <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         serve_prev_q  <= serve;
         mode_prev_q   <= mode;
         ball_en_q     <= ball_en_d;
         ball_launch_q <= ball_launch_d;
         serve_side_q  <= serve_side_d;
         score_clr_q   <= score_clr_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
      end
   end

   assign state       = state_q;
   assign ball_en     = ball_en_q;
   assign ball_launch = ball_launch_q;
   assign serve_side  = serve_side_q;
   assign score_clr   = score_clr_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: table of vectors plus hand sequences,
// expected outputs queued per driven cycle and compared after the clock edge.
module tb_match_sequencer;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       serve;
   logic       serve_type;
   logic [1:0] mode;
   logic       point_p1;
   logic       point_p2;
   logic [4:0] p1_score;
   logic [4:0] p2_score;
   logic       ball_en;
   logic       ball_launch;
   logic       serve_side;
   logic       score_clr;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   typedef struct packed {
      logic [2:0] st;
      logic       en;
      logic       la;
      logic       side;
      logic       clr;
      logic       go;
      logic       win;
   } out_t;

   typedef struct packed {
      logic       tk;
      logic       sv;
      logic       stype;
      logic [1:0] md;
      logic       pp1;
      logic       pp2;
      out_t       exp;
   } vec_t;

   int   checks;
   int   errors;
   out_t sb[$];

   match_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .serve      (serve),
      .serve_type (serve_type),
      .mode       (mode),
      .point_p1   (point_p1),
      .point_p2   (point_p2),
      .p1_score   (p1_score),
      .p2_score   (p2_score),
      .ball_en    (ball_en),
      .ball_launch(ball_launch),
      .serve_side (serve_side),
      .score_clr  (score_clr),
      .game_over  (game_over),
      .winner     (winner),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk(input logic [2:0] st, input logic en, input logic la,
                               input logic side, input logic clr, input logic go,
                               input logic win);
      out_t o;
      o.st = st; o.en = en; o.la = la; o.side = side; o.clr = clr; o.go = go; o.win = win;
      return o;
   endfunction

   function automatic out_t dut_out();
      return mk(state, ball_en, ball_launch, serve_side, score_clr, game_over, winner);
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d en=%b la=%b side=%b clr=%b go=%b win=%b, want st=%0d en=%b la=%b side=%b clr=%b go=%b win=%b",
                  name, act.st, act.en, act.la, act.side, act.clr, act.go, act.win,
                  exp.st, exp.en, exp.la, exp.side, exp.clr, exp.go, exp.win);
      end
   endtask

   // One clock: queue the expectation for the inputs already driven, then compare
   task automatic cyc(input string name, input out_t e);
      out_t x;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         x = sb.pop_front();
         check(name, dut_out(), x);
      end
   endtask

   vec_t tbl[8];

   initial begin
      checks = 0;
      errors = 0;

      // Manual serve, point by p2, ignored point outside PLAY
      tbl[0] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0)};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0)};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0)};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd2, 1, 1, 0, 0, 0, 0)};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd2, 1, 0, 0, 0, 0, 0)};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, mk(3'd3, 0, 0, 0, 0, 0, 0)};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0)};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0)};

      rst_n = 1'b0; tick = 1'b0; serve = 1'b0; serve_type = 1'b1; mode = 2'b00;
      point_p1 = 1'b0; point_p2 = 1'b0; p1_score = 5'd0; p2_score = 5'd0;
      #8;
      check("reset", dut_out(), mk(3'd0, 0, 0, 0, 0, 0, 0));
      #4 rst_n = 1'b1;

      foreach (tbl[i]) begin
         tick = tbl[i].tk; serve = tbl[i].sv; serve_type = tbl[i].stype;
         mode = tbl[i].md; point_p1 = tbl[i].pp1; point_p2 = tbl[i].pp2;
         cyc($sformatf("vec%0d", i), tbl[i].exp);
      end
      point_p1 = 1'b0;

      // Pause end with scores 3/4 returns to SERVE_WAIT on the 60th tick
      p1_score = 5'd3; p2_score = 5'd4; tick = 1'b1;
      for (int i = 0; i < 59; i++) cyc("pause_hold", mk(3'd3, 0, 0, 0, 0, 0, 0));
      cyc("pause_end", mk(3'd1, 0, 0, 0, 0, 0, 0));

      // Auto serve: 29 ticks wait (serve edge ignored), 30th launches
      serve_type = 1'b0;
      for (int i = 0; i < 29; i++) begin
         serve = (i >= 10 && i < 20);
         cyc("auto_wait", mk(3'd1, 0, 0, 0, 0, 0, 0));
      end
      serve = 1'b0;
      cyc("auto_launch", mk(3'd2, 1, 1, 0, 0, 0, 0));
      tick = 1'b0;

      // Simultaneous points: p1 priority, p2 serves
      point_p1 = 1'b1; point_p2 = 1'b1;
      cyc("both_points", mk(3'd3, 0, 0, 1, 0, 0, 0));
      point_p1 = 1'b0; point_p2 = 1'b0;

      // p1 reaches 15: GAME_OVER, winner 0
      p1_score = 5'd15; p2_score = 5'd0; tick = 1'b1;
      for (int i = 0; i < 59; i++) cyc("pause2_hold", mk(3'd3, 0, 0, 1, 0, 0, 0));
      cyc("p1_wins", mk(3'd4, 0, 0, 1, 0, 1, 0));
      tick = 1'b0;
      cyc("go_hold", mk(3'd4, 0, 0, 1, 0, 1, 0));
      serve = 1'b1;
      cyc("go_exit", mk(3'd0, 0, 0, 0, 1, 0, 0));
      serve = 1'b0;
      cyc("clr_pulse_end", mk(3'd0, 0, 0, 0, 0, 0, 0));

      // Second match: p2 reaches 15, winner 1
      serve_type = 1'b1; p1_score = 5'd3; p2_score = 5'd15;
      serve = 1'b1; cyc("g2_sw", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b0; cyc("g2_sw2", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b1; cyc("g2_play", mk(3'd2, 1, 1, 0, 0, 0, 0));
      serve = 1'b0; point_p1 = 1'b1; cyc("g2_point", mk(3'd3, 0, 0, 1, 0, 0, 0));
      point_p1 = 1'b0; tick = 1'b1;
      for (int i = 0; i < 59; i++) cyc("g2_pause", mk(3'd3, 0, 0, 1, 0, 0, 0));
      cyc("p2_wins", mk(3'd4, 0, 0, 1, 0, 1, 1));
      tick = 1'b0;
      serve = 1'b1; cyc("g2_exit", mk(3'd0, 0, 0, 0, 1, 0, 0));
      serve = 1'b0; cyc("g2_idle", mk(3'd0, 0, 0, 0, 0, 0, 0));

      // Mode change in PLAY aborts, outranking a point pulse
      p1_score = 5'd0; p2_score = 5'd0;
      serve = 1'b1; cyc("ab_sw", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b0; cyc("ab_sw2", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b1; cyc("ab_play", mk(3'd2, 1, 1, 0, 0, 0, 0));
      serve = 1'b0; mode = 2'b01; point_p1 = 1'b1;
      cyc("mode_abort", mk(3'd0, 0, 0, 0, 1, 0, 0));
      point_p1 = 1'b0;
      cyc("abort_after", mk(3'd0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset mid-pause, then a fresh serve edge is required
      serve = 1'b1; cyc("rs_sw", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b0; cyc("rs_sw2", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b1; cyc("rs_play", mk(3'd2, 1, 1, 0, 0, 0, 0));
      serve = 1'b0; point_p1 = 1'b1; cyc("rs_point", mk(3'd3, 0, 0, 1, 0, 0, 0));
      point_p1 = 1'b0; tick = 1'b1;
      for (int i = 0; i < 5; i++) cyc("rs_pause", mk(3'd3, 0, 0, 1, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1 check("async_reset", dut_out(), mk(3'd0, 0, 0, 0, 0, 0, 0));
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc("post_reset_idle", mk(3'd0, 0, 0, 0, 0, 0, 0));
      serve = 1'b1; cyc("post_reset_serve", mk(3'd1, 0, 0, 0, 0, 0, 0));
      serve = 1'b0; tick = 1'b0;

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 5'd15: score at which a match ends.
REQ-002 Parameter AUTO_DELAY, default 8'd30: tick pulses before an auto serve launches; legal range 1..255.
REQ-003 Parameter PAUSE_TICKS, default 8'd60: tick pulses of post-point pause; legal range 1..255.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 tick  in  1  one-cycle frame/time-base pulse.
REQ-007 serve  in  1  serve trigger, synchronous level; only its rising edge is used.
REQ-008 serve_type  in  1  0 = auto serve, 1 = manual serve.
REQ-009 mode  in  2  game mode: 00 tennis, 01 soccer, 10 squash, 11 practice.
REQ-010 point_p1, point_p2  in  1 each  one-cycle pulse: player 1 / player 2 scored.
REQ-011 p1_score, p2_score  in  5 each  current scores from the game datapath.
REQ-012 ball_en  out  1  high = ball may move.
REQ-013 ball_launch  out  1  one-cycle pulse: reload ball at the serve position.
REQ-014 serve_side  out  1  0 = player 1 serves, 1 = player 2 serves.
REQ-015 score_clr  out  1  one-cycle pulse: clear both scores.
REQ-016 game_over  out  1  high while in GAME_OVER.
REQ-017 winner  out  1  0 = player 1, 1 = player 2; valid only while game_over = 1.
REQ-018 state  out  3  FSM state: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4.

Function
REQ-019 All outputs are registered; responses appear the clock after the triggering input cycle.
REQ-020 serve edge: serve = 1 in the current cycle and 0 in the previous cycle, using a registered previous sample.
REQ-021 The 8-bit tick counter clears on every state entry and increments only on tick while in SERVE_WAIT or POINT_PAUSE.
REQ-022 IDLE: ball_en = 0; a serve edge moves to SERVE_WAIT.
REQ-023 SERVE_WAIT, manual: a serve edge moves to PLAY; tick is ignored.
REQ-024 SERVE_WAIT, auto: the AUTO_DELAY-th tick (counter == AUTO_DELAY-1 with tick = 1) moves to PLAY; serve is ignored.
REQ-025 ball_launch is 1 for exactly the one cycle in which state first reads PLAY; no other transition asserts it.
REQ-026 PLAY: ball_en = 1; a point_p1 or point_p2 pulse moves to POINT_PAUSE.
REQ-027 ball_en = 0 in every state other than PLAY.
REQ-028 On PLAY exit, the conceding player becomes server: point_p1 sets serve_side = 1, point_p2 sets serve_side = 0.
REQ-029 If point_p1 and point_p2 arrive in the same cycle, point_p1 wins: serve_side = 1.
REQ-030 Point pulses outside PLAY are ignored.
REQ-031 POINT_PAUSE: the PAUSE_TICKS-th tick evaluates scores, then moves as REQ-032/033.
REQ-032 If p1_score >= WIN_SCORE or p2_score >= WIN_SCORE, go to GAME_OVER with winner = (p2_score >= WIN_SCORE && p1_score < WIN_SCORE); a tie gives player 1.
REQ-033 Otherwise go to SERVE_WAIT.
REQ-034 GAME_OVER: game_over = 1; a serve edge goes to IDLE with one-cycle score_clr and serve_side = 0.
REQ-035 A change of mode (current differs from registered previous) in any state other than IDLE aborts to IDLE the next cycle with one-cycle score_clr.
REQ-036 The mode-change abort has priority over every other transition that cycle.
REQ-037 tick and a serve edge in the same cycle: each is applied according to the active serve_type only.
REQ-038 Unused state encodings 5..7 return to IDLE on the next clock.

Reset
REQ-039 rst_n = 0 forces, asynchronously: state = IDLE, counter = 0, previous-serve = 0, previous-mode = mode-register 00, ball_en = 0, ball_launch = 0, score_clr = 0, serve_side = 0, game_over = 0, winner = 0.
REQ-040 Reset mid-match discards the pending launch/pause; the first action after release requires a fresh serve edge.

Verification
REQ-041 Manual serve: serve_type = 1, pulse serve twice -> state 0→1→2, ball_launch high one cycle, ball_en = 1.
REQ-042 Auto serve: serve_type = 0, 30 ticks in SERVE_WAIT -> PLAY exactly after the 30th tick; 29 ticks -> still SERVE_WAIT.
REQ-043 Point: in PLAY pulse point_p2 -> POINT_PAUSE, ball_en = 0, serve_side = 0; 60 ticks with scores 3/4 -> SERVE_WAIT.
REQ-044 Match end: p1_score = 15 at pause end -> GAME_OVER, winner = 0; serve edge -> IDLE with one-cycle score_clr.
REQ-045 Simultaneous point_p1/point_p2 in PLAY -> serve_side = 1; mode change during PLAY -> IDLE plus score_clr.
REQ-046 rst_n low in POINT_PAUSE mid-count -> all outputs at reset values immediately, without a clock edge.
